audio_dac_out: RTL and testbench
================================

// Module: audio_dac_out
// PURPOSE
//  Parametrised audio output stage between the AM demodulator and the 1-bit audio pin.
//  Captures demodulated samples on a tick, applies shift gain with saturation and optional DC removal,
//  then drives a single output bit as either period-based PWM or first-order sigma-delta.
//  Flags underrun (no samples arriving) and overrun (samples arriving faster than the PWM frame rate).
// PARAMETERS
//  IN_W             16  sample width; unsigned magnitude in, midscale 2^(IN_W-1)
//  PWM_BITS          8  PWM counter width; period = 2^PWM_BITS clocks
//  DC_SHIFT          8  DC-estimate leak, time constant 2^DC_SHIFT samples
//  UNDERRUN_PERIODS 16  PWM periods with no new sample before underrun asserts
// PORTS
//  clk        in   1         system clock
//  RST        in   1         synchronous reset, active-high
//  in_sample  in   IN_W      demodulated sample, unsigned
//  in_tick    in   1         one-cycle strobe, in_sample valid
//  gain       in   4         left shift applied to sample, 0..15
//  dc_en      in   1         1 = subtract running DC estimate and re-centre at midscale
//  mode       in   1         0 = PWM, 1 = sigma-delta
//  pwm_out    out  1         registered 1-bit audio output
//  underrun   out  1         level; high while starved
//  overrun    out  1         one-cycle pulse; an unconsumed pending sample was overwritten
// BEHAVIOUR
//  Reset: all registers 0, including pwm_out, underrun, overrun, counters, dc_acc, pending, duty and mode_act.
//  Reset mid-period discards the pending sample; the period counter restarts at 0.
//  Pipeline, fully pipelined, accepts in_tick every cycle:
//   S1 (tick+1): g = in_sample << gain, evaluated at IN_W+15 bits.
//       If any bit above IN_W-1 is set, g = 2^IN_W-1.
//   S2 (tick+2), dc_en=1: d = g - dc_est + 2^(IN_W-1), clamped to [0, 2^IN_W-1].
//       Here dc_est = dc_acc >> DC_SHIFT, and dc_acc += g - dc_est, signed, IN_W+DC_SHIFT+1 bits.
//   S2, dc_en=0: d = g; dc_acc holds.
//   S2 writes pending <= d and sets pend_v. If pend_v was already 1, overrun pulses for that cycle.
//  Period counter cnt (PWM_BITS) increments every clock in both modes, so boundaries always exist.
//  Boundary = cycle where cnt == 2^PWM_BITS-1. At a boundary:
//   - mode_act <= mode, so mode changes take effect only at a boundary.
//   - duty <= pending[IN_W-1 -: PWM_BITS]; pend_v <= 0.
//   - If pend_v was 0, starve_cnt increments, saturating at UNDERRUN_PERIODS.
//   - If starve_cnt reaches UNDERRUN_PERIODS, underrun <= 1.
//   - Without a new sample, duty keeps the last value.
//  If an S2 write and a boundary fall in the same cycle, the boundary consumes the new value and pend_v ends 0.
//  Any S2 write clears starve_cnt and underrun on the next clock.
//  PWM mode: pwm_out <= (cnt < duty). duty=0 gives always low; duty=2^PWM_BITS-1 gives high 255/256.
//  Sigma-delta mode: sd_acc (IN_W+1) <= sd_acc[IN_W-1:0] + pending every clock; pwm_out <= carry bit.
//   This uses live pending, not duty. sd_acc is cleared on each mode_act change.
//  Overall latency: tick to duty visible is 2 clocks plus the wait to the next boundary.
//   Tick to sigma-delta input is 3 clocks.
// TESTING (IN_W=16, PWM_BITS=8, DC_SHIFT=4, UNDERRUN_PERIODS=4)
//  1 Reset: RST high 3 clks with random inputs -> pwm_out=underrun=overrun=0; first period after release all low.
//  2 PWM, gain=0, dc_en=0, one tick of 0x4000 -> from the next boundary, exactly 64 high clocks per 256, high at cnt 0..63.
//  3 Saturation: 0x9000 with gain=1 -> pending 0xFFFF, duty 0xFF, 255 high per period; gain=15 with 0x0001 -> 0x8000.
//  4 Sigma-delta, one sample 0x8000 -> pwm_out alternates 1/0, 128 highs per 256; 0x0000 -> constant 0.
//  5 DC removal: 300 ticks of 0x6000 -> pending settles to 0x8000 +/-2, duty 0x80.
//    A step to 0x7000 -> first output about 0x9000, then decays back to 0x8000.
//  6 Flags: no ticks -> underrun rises exactly at the 4th empty boundary and clears 1 clk after the next S2 write.
//    Two ticks 10 clks apart within a period -> overrun pulses once, and the second value is the one used.

Source files
------------

// File: rtl/audio_dac_out.sv
// Audio output stage: samples are gained with saturation, optionally DC-removed, then
// rendered on one pin as frame-based PWM or first-order sigma-delta, with starvation/overrun flags.
module audio_dac_out #(
    parameter int IN_W             = 16,
    parameter int PWM_BITS         = 8,
    parameter int DC_SHIFT         = 8,
    parameter int UNDERRUN_PERIODS = 16
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [IN_W-1:0] in_sample,
    input  logic            in_tick,
    input  logic [3:0]      gain,
    input  logic            dc_en,
    input  logic            mode,
    output logic            pwm_out,
    output logic            underrun,
    output logic            overrun
);
    localparam int GW = IN_W + 15;
    localparam int AW = IN_W + DC_SHIFT + 1;
    localparam int DW = IN_W + 3;
    localparam int SW = $clog2(UNDERRUN_PERIODS + 1);
    localparam logic signed [DW-1:0] MID        = DW'(2 ** (IN_W - 1));
    localparam logic [SW-1:0]        STARVE_MAX = SW'(UNDERRUN_PERIODS);
    localparam logic [SW-1:0]        STARVE_LST = SW'(UNDERRUN_PERIODS - 1);

    // S1: gain shift with saturation
    logic [GW-1:0]   shifted;
    logic [IN_W-1:0] g1;
    logic            v1;

    assign shifted = GW'(in_sample) << gain;

    always_ff @(posedge clk) begin
        if (RST) begin
            g1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= in_tick;
            g1 <= (|shifted[GW-1:IN_W]) ? '1 : shifted[IN_W-1:0];
        end
    end

    // S2: leaky DC estimate removal, re-centred at midscale
    logic signed [AW-1:0] dc_acc;
    logic signed [IN_W:0] dc_est;
    logic signed [DW-1:0] d_wide;
    logic [IN_W-1:0]      d_clamp;
    logic [IN_W-1:0]      s2_val;

    assign dc_est = (IN_W + 1)'(dc_acc >>> DC_SHIFT);
    assign d_wide = DW'($signed({1'b0, g1})) - DW'(dc_est) + MID;
    assign s2_val = dc_en ? d_clamp : g1;

    always_comb begin
        d_clamp = d_wide[IN_W-1:0];
        if (d_wide[DW-1])
            d_clamp = '0;
        else if (|d_wide[DW-2:IN_W])
            d_clamp = '1;
    end

    // Output stage
    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;
    logic [IN_W-1:0]     pending;
    logic                pend_v;
    logic                wr_q;
    logic                mode_act;
    logic [SW-1:0]       starve_cnt;
    logic [IN_W-1:0]     sd_acc;
    logic [IN_W:0]       sd_sum;
    logic                boundary;

    assign boundary = &cnt;
    assign sd_sum   = {1'b0, sd_acc} + {1'b0, pending};

    always_ff @(posedge clk) begin
        if (RST) begin
            cnt        <= '0;
            duty       <= '0;
            pending    <= '0;
            pend_v     <= 1'b0;
            wr_q       <= 1'b0;
            mode_act   <= 1'b0;
            starve_cnt <= '0;
            sd_acc     <= '0;
            dc_acc     <= '0;
            pwm_out    <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            overrun <= v1 && pend_v;
            wr_q    <= v1;

            if (v1) begin
                pending <= s2_val;
                if (dc_en)
                    dc_acc <= dc_acc + AW'($signed({1'b0, g1})) - AW'(dc_est);
            end

            // a write landing on the boundary is consumed immediately
            if (boundary) begin
                duty     <= v1 ? s2_val[IN_W-1 -: PWM_BITS] : pending[IN_W-1 -: PWM_BITS];
                pend_v   <= 1'b0;
                mode_act <= mode;
            end else if (v1) begin
                pend_v <= 1'b1;
            end

            if (wr_q) begin
                starve_cnt <= '0;
                underrun   <= 1'b0;
            end else if (boundary && !pend_v && !v1) begin
                if (starve_cnt < STARVE_MAX)
                    starve_cnt <= starve_cnt + 1'b1;
                if (starve_cnt >= STARVE_LST)
                    underrun <= 1'b1;
            end

            if (boundary && (mode != mode_act))
                sd_acc <= '0;
            else
                sd_acc <= sd_sum[IN_W-1:0];

            if (mode_act)
                pwm_out <= sd_sum[IN_W];
            else
                pwm_out <= (cnt < duty);
        end
    end
endmodule

// File: tb/tb_audio_dac_out.sv
// Randomized self-checking bench for audio_dac_out; expectations come from arithmetic
// on the sample/gain/DC rules and the frame timing, not from the RTL structure.
module tb_audio_dac_out;
    localparam int IN_W = 16, PWM_BITS = 8, DC_SHIFT = 4, UNDER = 4;

    logic            clk = 1'b0;
    logic            RST = 1'b1;
    logic [IN_W-1:0] in_sample = '0;
    logic            in_tick = 1'b0;
    logic [3:0]      gain = '0;
    logic            dc_en = 1'b0;
    logic            mode = 1'b0;
    logic            pwm_out, underrun, overrun;

    always #5 clk = ~clk;

    audio_dac_out #(.IN_W(IN_W), .PWM_BITS(PWM_BITS), .DC_SHIFT(DC_SHIFT),
                    .UNDERRUN_PERIODS(UNDER)) dut (
        .clk(clk), .RST(RST), .in_sample(in_sample), .in_tick(in_tick), .gain(gain),
        .dc_en(dc_en), .mode(mode), .pwm_out(pwm_out), .underrun(underrun), .overrun(overrun)
    );

    int     n_chk = 0, n_err = 0;
    int     n = 0;          // clock edges since reset release
    longint m_acc = 0;      // reference DC accumulator

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int gain_sat(input int s, input int g);
        longint x = longint'(s) << g;
        return (x > 65535) ? 65535 : int'(x);
    endfunction

    // leaky mean tracker with time constant 2^DC_SHIFT samples
    function automatic int dc_model(input int g);
        longint est = m_acc >>> DC_SHIFT;
        longint dd  = longint'(g) - est + 32768;
        m_acc = m_acc + g - est;
        if (dd < 0) return 0;
        if (dd > 65535) return 65535;
        return int'(dd);
    endfunction

    function automatic int next_bnd(input int w);
        return ((w + 255) / 256) * 256;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic step_to(input int target);
        while (n < target) step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_sample = 16'($urandom);
            in_tick   = 1'($urandom);
            gain      = 4'($urandom);
            dc_en     = 1'($urandom);
            mode      = 1'($urandom);
            @(posedge clk);
            #1;
            chk("rst_pwm", pwm_out, 0);
            chk("rst_underrun", underrun, 0);
            chk("rst_overrun", overrun, 0);
        end
        RST = 1'b0; in_tick = 1'b0; in_sample = '0; gain = '0; dc_en = 1'b0; mode = 1'b0;
        n = 0;
    endtask

    // tick is sampled at edge 'at'
    task automatic send_tick(input int val, input int at);
        step_to(at - 1);
        in_sample = 16'(val);
        in_tick   = 1'b1;
        step();
        in_tick   = 1'b0;
    endtask

    // One frame following boundary edge b; v is the duty (PWM) or the pending value (sigma-delta)
    task automatic measure(input int b, input bit sd, input int v, input string tag, output int highs);
        int bad = 0, ov = 0;
        longint e;
        highs = 0;
        step_to(b);
        for (int j = 0; j < 256; j++) begin
            step();
            if (sd) e = (((longint'(j) + 1) * v) >> 16) - ((longint'(j) * v) >> 16);
            else    e = (j < v) ? 1 : 0;
            if (pwm_out) highs++;
            if (longint'(pwm_out) != e) bad++;
            if (overrun) ov++;
        end
        chk({tag, "_highs"}, highs, sd ? (v >> 8) : v);
        chk({tag, "_shape"}, bad, 0);
        chk({tag, "_ovr"}, ov, 0);
    endtask

    task automatic pwm_case(input int s, input int g, input string tag);
        int hi;
        do_reset();
        gain = 4'(g);
        send_tick(s, 11);
        measure(256, 1'b0, gain_sat(s, g) >> 8, tag, hi);
    endtask

    task automatic sd_case(input int v, input string tag);
        int hi;
        do_reset();
        mode = 1'b1;
        send_tick(v, 11);
        measure(256, 1'b1, v, tag, hi);
    endtask

    initial begin
        int hi, d, a, b, ov, ov_at;

        // reset, first frame, and a reset that discards a pending sample
        do_reset();
        measure(0, 1'b0, 0, "rst_first", hi);
        send_tick(16'hFFFF, 300);
        step_to(400);
        do_reset();
        measure(0, 1'b0, 0, "midrst_p1", hi);
        measure(256, 1'b0, 0, "midrst_p2", hi);

        // PWM duty and saturation
        pwm_case(16'h4000, 0, "pwm_4000");
        pwm_case(16'h9000, 1, "sat_g1");
        pwm_case(16'h0001, 15, "sat_g15");
        pwm_case(16'h0000, 0, "pwm_zero");
        for (int i = 0; i < 4; i++)
            pwm_case(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), "pwm_rand");

        // sigma-delta
        sd_case(16'h8000, "sd_8000");
        sd_case(16'h0000, "sd_zero");
        for (int i = 0; i < 2; i++)
            sd_case(int'($urandom_range(0, 65535)), "sd_rand");

        // DC removal: settle, step, decay
        do_reset();
        dc_en = 1'b1;
        m_acc = 0;
        d = 0;
        for (int i = 0; i < 300; i++) begin
            send_tick(16'h6000, n + 4);
            d = dc_model(16'h6000);
        end
        measure(next_bnd(n + 1), 1'b0, d >> 8, "dc_settle", hi);
        chk("dc_settle_mid", hi, 128);
        send_tick(16'h7000, n + 3);
        d = dc_model(16'h7000);
        measure(next_bnd(n + 1), 1'b0, d >> 8, "dc_step", hi);
        chk("dc_step_hi", hi, 144);
        for (int i = 0; i < 100; i++) begin
            send_tick(16'h7000, n + 4);
            d = dc_model(16'h7000);
        end
        measure(next_bnd(n + 1), 1'b0, d >> 8, "dc_decay", hi);
        chk("dc_decay_mid", hi, 128);
        dc_en = 1'b0;

        // underrun: rises at the 4th empty boundary, clears one clock after the next write
        do_reset();
        step_to(1023);
        chk("under_pre", underrun, 0);
        step();
        chk("under_rise", underrun, 1);
        send_tick(16'h1234, 1031);
        step();
        chk("under_hold", underrun, 1);
        step();
        chk("under_clr", underrun, 0);

        // overrun: two ticks in one frame, the later value wins
        do_reset();
        a = int'($urandom_range(0, 65535));
        b = int'($urandom_range(0, 65535));
        ov = 0;
        ov_at = -1;
        for (int k = 0; k < 255; k++) begin
            in_tick   = (n == 19 || n == 29);
            in_sample = 16'((n == 19) ? a : b);
            step();
            if (overrun) begin
                ov++;
                ov_at = n;
            end
        end
        in_tick = 1'b0;
        chk("ovr_count", ov, 1);
        chk("ovr_edge", ov_at, 31);
        measure(256, 1'b0, b >> 8, "ovr_second", hi);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
